// File: rtl/system_pkg.sv
// Shared types and helpers for the board-level system top.
//  - fetch_state_e : instruction-fetch FSM states
//  - DISP_*        : disp_sel codes for the 7-segment display source
//  - seg7_font     : hex nibble -> active-low {g,f,e,d,c,b,a}
//  - rom_word      : contents of the 16-word internal instruction ROM
package system_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } fetch_state_e;

   localparam logic [2:0] DISP_PC    = 3'd0;
   localparam logic [2:0] DISP_INSTR = 3'd1;
   localparam logic [2:0] DISP_RX    = 3'd2;
   localparam logic [2:0] DISP_CYCLE = 3'd4;

   // Standard hex font, segments active-low, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7_font(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // ROM word k repeats nibble k four times
   function automatic logic [15:0] rom_word(input logic [3:0] k);
      return {k, k, k, k};
   endfunction

endpackage

// File: rtl/system_seg7_scan.sv
// 8-digit multiplexed 7-segment scanner.
//  clk, rst_n     : clock, async active-low reset
//  value[31:0]    : digit i shows nibble i (digit 0 rightmost)
//  segdisp_data   : active-low {dp,g,f,e,d,c,b,a}, dp always off
//  segdisp_sel_n  : active-low one-hot digit enable
module seg7_scan
   import system_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] value,
   output logic [7:0]  segdisp_data,
   output logic [7:0]  segdisp_sel_n
);

   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        idx;

   // Digit index advances every SCAN_DIV cycles; outputs follow the index one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt      <= '0;
         idx           <= 3'd0;
         segdisp_sel_n <= 8'hFE;
         segdisp_data  <= 8'hFF;
      end else begin
         if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
         segdisp_sel_n <= ~(8'd1 << idx);
         segdisp_data  <= {1'b1, seg7_font(value[{idx, 2'b00} +: 4])};
      end
   end

endmodule

// File: rtl/system.sv
// Board-level top: clock dividers, instruction fetch (internal ROM or async
// PSRAM), 32-bit CPU-tick counter, 7-seg display, LEDs, optional UART echo.
//  clk_100M, rst (async active-low), rst_counter (sync clear of cycle count)
//  rom_selector (0 ROM / 1 PSRAM), boot_addr_sel (sampled in reset), disp_sel
//  segdisp_data/segdisp_sel_n, led_out = instr[15:0], clk_50M_out, clk_cpu_out
//  psram_* async PSRAM pins (psram_data read only), com_RxD/com_TxD UART
// Build option: define SYSTEM_UART_EN to enable the 8N1 receiver with echo.
module system
   import system_pkg::*;
#(
   parameter int unsigned CPU_DIV     = 4,
   parameter int unsigned PSRAM_WAIT  = 8,
   parameter int unsigned SCAN_DIV    = 100000,
   parameter int unsigned BAUD_DIV    = 868,
   parameter logic [22:0] BOOT_ADDR_0 = 23'h000000,
   parameter logic [22:0] BOOT_ADDR_1 = 23'h400000
) (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        rst_counter,
   input  logic        rom_selector,
   input  logic        boot_addr_sel,
   input  logic [2:0]  disp_sel,
   input  logic        com_RxD,
   output logic [7:0]  segdisp_data,
   output logic [7:0]  segdisp_sel_n,
   output logic [15:0] led_out,
   output logic        clk_50M_out,
   output logic        clk_cpu_out,
   output logic [22:0] psram_addr,
   inout  wire  [15:0] psram_data,
   output logic        psram_ce,
   output logic        psram_oe,
   output logic        psram_we,
   output logic        psram_ub,
   output logic        psram_lb,
   output logic        psram_adv,
   output logic        psram_clk,
   output logic        psram_cre,
   output logic        com_TxD
);

   localparam int unsigned DIV_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
   localparam int unsigned WAIT_W = (PSRAM_WAIT > 1) ? $clog2(PSRAM_WAIT) : 1;

   logic [DIV_W-1:0]  div_cnt;
   logic              cpu_tick;
   logic [31:0]       cycle;
   logic [7:0]        rx_byte;
   fetch_state_e      state, state_next;
   logic [22:0]       pc, pc_next;
   logic [15:0]       instr, instr_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic [31:0]       disp_value_c;

   // Async PSRAM: write, byte-lane, burst and config pins are tied off
   assign psram_we   = 1'b1;
   assign psram_ub   = 1'b0;
   assign psram_lb   = 1'b0;
   assign psram_adv  = 1'b0;
   assign psram_clk  = 1'b0;
   assign psram_cre  = 1'b0;
   assign psram_addr = pc;
   assign led_out    = instr;

   // Clock outputs; cpu_tick marks each rising toggle of clk_cpu_out
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         clk_50M_out <= 1'b0;
         clk_cpu_out <= 1'b0;
         div_cnt     <= '0;
         cpu_tick    <= 1'b0;
      end else begin
         clk_50M_out <= ~clk_50M_out;
         cpu_tick    <= 1'b0;
         if (div_cnt == DIV_W'(CPU_DIV - 1)) begin
            div_cnt     <= '0;
            clk_cpu_out <= ~clk_cpu_out;
            cpu_tick    <= ~clk_cpu_out;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Tick counter; the synchronous clear wins over a coincident tick
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst)             cycle <= 32'd0;
      else if (rst_counter) cycle <= 32'd0;
      else if (cpu_tick)    cycle <= cycle + 32'd1;
   end

   // Fetch FSM next state; ticks arriving during READ are dropped
   always_comb begin
      state_next = state;
      pc_next    = pc;
      instr_next = instr;
      wait_next  = wait_cnt;
      case (state)
         IDLE: begin
            if (cpu_tick) begin
               if (!rom_selector) begin
                  instr_next = rom_word(pc[3:0]);
                  pc_next    = pc + 23'd1;
               end else begin
                  state_next = READ;
                  wait_next  = '0;
               end
            end
         end
         READ: begin
            if (wait_cnt == WAIT_W'(PSRAM_WAIT - 1)) begin
               instr_next = psram_data;
               pc_next    = pc + 23'd1;
               state_next = IDLE;
            end else begin
               wait_next = wait_cnt + WAIT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Fetch FSM registers; ce/oe are low exactly while the FSM sits in READ
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= boot_addr_sel ? BOOT_ADDR_1 : BOOT_ADDR_0;
         instr    <= 16'd0;
         wait_cnt <= '0;
         psram_ce <= 1'b1;
         psram_oe <= 1'b1;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         instr    <= instr_next;
         wait_cnt <= wait_next;
         psram_ce <= (state_next != READ);
         psram_oe <= (state_next != READ);
      end
   end

   // Display source select
   always_comb begin
      disp_value_c = 32'd0;
      case (disp_sel)
         DISP_PC:    disp_value_c = {9'd0, pc};
         DISP_INSTR: disp_value_c = {16'd0, instr};
         DISP_RX:    disp_value_c = {24'd0, rx_byte};
         DISP_CYCLE: disp_value_c = cycle;
         default:    disp_value_c = 32'd0;
      endcase
   end

   seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk           (clk_100M),
      .rst_n         (rst),
      .value         (disp_value_c),
      .segdisp_data  (segdisp_data),
      .segdisp_sel_n (segdisp_sel_n)
   );

`ifdef SYSTEM_UART_EN
   localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [1:0]        rx_sync;
   logic              rx_busy;
   logic [3:0]        rx_bit;
   logic [BAUD_W-1:0] rx_cnt;
   logic [7:0]        rx_shift;
   logic              rx_done;
   logic              tx_busy;
   logic [3:0]        tx_bits;
   logic [BAUD_W-1:0] tx_cnt;
   logic [8:0]        tx_shift;

   // 8N1 receiver: rx_bit 0 = start check at half-bit, 1..8 data, 9 stop
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         rx_sync  <= 2'b11;
         rx_busy  <= 1'b0;
         rx_bit   <= 4'd0;
         rx_cnt   <= '0;
         rx_shift <= 8'd0;
         rx_byte  <= 8'd0;
         rx_done  <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], com_RxD};
         rx_done <= 1'b0;
         if (!rx_busy) begin
            if (!rx_sync[1]) begin
               rx_busy <= 1'b1;
               rx_bit  <= 4'd0;
               rx_cnt  <= BAUD_W'(BAUD_DIV / 2 - 1);
            end
         end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - BAUD_W'(1);
         end else begin
            rx_cnt <= BAUD_W'(BAUD_DIV - 1);
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               if (rx_sync[1]) rx_busy <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_busy <= 1'b0;
               if (rx_sync[1]) begin
                  rx_byte <= rx_shift;
                  rx_done <= 1'b1;
               end
            end else begin
               rx_shift <= {rx_sync[1], rx_shift[7:1]};
            end
         end
      end
   end

   // Echo transmitter; a byte completing while busy is not echoed
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         tx_busy  <= 1'b0;
         tx_bits  <= 4'd0;
         tx_cnt   <= '0;
         tx_shift <= 9'h1FF;
         com_TxD  <= 1'b1;
      end else if (!tx_busy) begin
         if (rx_done) begin
            tx_busy  <= 1'b1;
            com_TxD  <= 1'b0;
            tx_shift <= {1'b1, rx_byte};
            tx_bits  <= 4'd9;
            tx_cnt   <= BAUD_W'(BAUD_DIV - 1);
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - BAUD_W'(1);
      end else if (tx_bits == 4'd0) begin
         tx_busy <= 1'b0;
      end else begin
         com_TxD  <= tx_shift[0];
         tx_shift <= {1'b1, tx_shift[8:1]};
         tx_bits  <= tx_bits - 4'd1;
         tx_cnt   <= BAUD_W'(BAUD_DIV - 1);
      end
   end
`else
   logic unused_uart;
   assign unused_uart = com_RxD | (BAUD_DIV == 0);
   assign rx_byte     = 8'd0;
   assign com_TxD     = 1'b1;
`endif

endmodule

// File: tb/tb_system.sv
`timescale 1ns/1ps
module tb_system;

   localparam int unsigned BAUD = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_counter;
   logic        rom_selector;
   logic        boot_addr_sel;
   logic [2:0]  disp_sel;
   logic        com_RxD;
   logic [7:0]  segdisp_data;
   logic [7:0]  segdisp_sel_n;
   logic [15:0] led_out;
   logic        clk_50M_out;
   logic        clk_cpu_out;
   logic [22:0] psram_addr;
   wire  [15:0] psram_data;
   logic        psram_ce, psram_oe, psram_we, psram_ub, psram_lb;
   logic        psram_adv, psram_clk, psram_cre;
   logic        com_TxD;
   logic        psram_const;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // PSRAM model: returns its address low half, or a fixed word in const mode
   assign psram_data = psram_const ? 16'h3333 : psram_addr[15:0];

   system #(.SCAN_DIV(4), .BAUD_DIV(BAUD)) dut (
      .clk_100M(clk), .rst(rst), .rst_counter(rst_counter),
      .rom_selector(rom_selector), .boot_addr_sel(boot_addr_sel),
      .disp_sel(disp_sel), .com_RxD(com_RxD),
      .segdisp_data(segdisp_data), .segdisp_sel_n(segdisp_sel_n),
      .led_out(led_out), .clk_50M_out(clk_50M_out), .clk_cpu_out(clk_cpu_out),
      .psram_addr(psram_addr), .psram_data(psram_data),
      .psram_ce(psram_ce), .psram_oe(psram_oe), .psram_we(psram_we),
      .psram_ub(psram_ub), .psram_lb(psram_lb), .psram_adv(psram_adv),
      .psram_clk(psram_clk), .psram_cre(psram_cre), .com_TxD(com_TxD)
   );

   // Hold reset 3 cycles, release on a falling edge: next posedge is edge 1
   task automatic apply_reset(input logic boot, input logic rom_sel);
      @(negedge clk);
      rst = 1'b0; boot_addr_sel = boot; rom_selector = rom_sel;
      rst_counter = 1'b0; com_RxD = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      psram_const = 1'b0; disp_sel = 3'd0;
      apply_reset(1'b0, 1'b0);
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if ({clk_50M_out, clk_cpu_out} !== 2'b00) begin
         n_fail++; $display("FAIL reset_clk_outs got %b want 00", {clk_50M_out, clk_cpu_out});
      end
      n_checks++;
      if (psram_addr !== 23'h0 || led_out !== 16'h0) begin
         n_fail++; $display("FAIL reset_pc_instr got %h/%h want 0/0", psram_addr, led_out);
      end
      n_checks++;
      if ({psram_ce, psram_oe, psram_we, psram_adv, psram_ub, psram_lb, psram_clk, psram_cre} !== 8'b1110_0000) begin
         n_fail++; $display("FAIL reset_psram_pins got %b want 11100000",
                            {psram_ce, psram_oe, psram_we, psram_adv, psram_ub, psram_lb, psram_clk, psram_cre});
      end
      n_checks++;
      if (segdisp_sel_n !== 8'hFE || segdisp_data !== 8'hFF) begin
         n_fail++; $display("FAIL reset_display got %h/%h want FE/FF", segdisp_sel_n, segdisp_data);
      end
      n_checks++;
      if (com_TxD !== 1'b1 || dut.cycle !== 32'd0 || dut.rx_byte !== 8'd0) begin
         n_fail++; $display("FAIL reset_misc got txd=%b cycle=%0d rx=%h want 1/0/00", com_TxD, dut.cycle, dut.rx_byte);
      end
   endtask

   // Clock periods and three ROM fetches from boot address 0
   task automatic test_clocks_rom();
      time r50[$];
      time rcpu[$];
      logic p50, pcpu;
      apply_reset(1'b0, 1'b0);
      p50 = 1'b0; pcpu = 1'b0;
      for (int e = 1; e <= 21; e++) begin
         @(posedge clk); #1;
         if (clk_50M_out && !p50) r50.push_back($time);
         if (clk_cpu_out && !pcpu) rcpu.push_back($time);
         p50 = clk_50M_out; pcpu = clk_cpu_out;
      end
      n_checks++;
      if (r50.size() < 2 || (r50[1] - r50[0]) != 20) begin
         n_fail++; $display("FAIL clk_50M_period got rises=%0d want period 20 ns", r50.size());
      end
      n_checks++;
      if (rcpu.size() < 2 || (rcpu[1] - rcpu[0]) != 80) begin
         n_fail++; $display("FAIL clk_cpu_period got rises=%0d want period 80 ns", rcpu.size());
      end
      n_checks++;
      if (psram_addr !== 23'd3 || led_out !== 16'h2222) begin
         n_fail++; $display("FAIL rom_fetch3 got pc=%h instr=%h want 3/2222", psram_addr, led_out);
      end
   endtask

   // PSRAM reads from boot address 1
   task automatic test_psram();
      int low_cnt;
      int guard;
      psram_const = 1'b0;
      apply_reset(1'b1, 1'b1);
      #1;
      n_checks++;
      if (psram_addr !== 23'h400000) begin
         n_fail++; $display("FAIL psram_boot_addr got %h want 400000", psram_addr);
      end
      guard = 0;
      do begin @(posedge clk); #1; guard++; end while (psram_ce && guard < 50);
      low_cnt = 0;
      while (!psram_ce && low_cnt < 50) begin
         n_checks++;
         if (psram_oe !== 1'b0 || psram_we !== 1'b1) begin
            n_fail++; $display("FAIL psram_read_pins got oe=%b we=%b want 0/1", psram_oe, psram_we);
         end
         low_cnt++; @(posedge clk); #1;
      end
      n_checks++;
      if (low_cnt != 8) begin
         n_fail++; $display("FAIL psram_ce_low got %0d cycles want 8", low_cnt);
      end
      n_checks++;
      if (led_out !== 16'h0000 || psram_addr !== 23'h400001) begin
         n_fail++; $display("FAIL psram_read1 got instr=%h pc=%h want 0000/400001", led_out, psram_addr);
      end
      guard = 0;
      while (psram_addr !== 23'h400002 && guard < 60) begin @(posedge clk); #1; guard++; end
      n_checks++;
      if (led_out !== 16'h0001 || psram_addr !== 23'h400002) begin
         n_fail++; $display("FAIL psram_read2 got instr=%h pc=%h want 0001/400002", led_out, psram_addr);
      end
   endtask

   // Tick counter: 25 ticks in 200 cycles, then synchronous clear
   task automatic test_counter();
      apply_reset(1'b0, 1'b0);
      disp_sel = 3'b100;
      repeat (200) @(posedge clk); #1;
      n_checks++;
      if (dut.cycle !== 32'd25) begin
         n_fail++; $display("FAIL cycle_count got %0d want 25", dut.cycle);
      end
      @(negedge clk); rst_counter = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (dut.cycle !== 32'd0) begin
         n_fail++; $display("FAIL cycle_clear got %0d want 0", dut.cycle);
      end
      @(negedge clk); rst_counter = 1'b0;
      repeat (15) @(posedge clk); #1;
      n_checks++;
      if (dut.cycle !== 32'd2) begin
         n_fail++; $display("FAIL cycle_recount got %0d want 2", dut.cycle);
      end
   endtask

   // Display scan of instr=3333: digits 0-3 '3', digits 4-7 '0'
   task automatic test_scan();
      logic [7:0] want_sel [8];
      int         pos;
      int         guard;
      int         digit;
      logic [7:0] prev;
      want_sel = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      psram_const = 1'b1;
      apply_reset(1'b0, 1'b1);
      disp_sel = 3'd1;
      guard = 0;
      while (led_out !== 16'h3333 && guard < 60) begin @(posedge clk); #1; guard++; end
      n_checks++;
      if (led_out !== 16'h3333) begin
         n_fail++; $display("FAIL scan_setup got instr=%h want 3333", led_out);
      end
      repeat (2) @(posedge clk); #1;
      pos = -1; prev = 8'h00;
      for (int c = 0; c < 40; c++) begin
         if (segdisp_sel_n !== prev) begin
            if (pos < 0) begin
               for (int k = 0; k < 8; k++) if (want_sel[k] == segdisp_sel_n) pos = k;
            end else begin
               pos = (pos + 1) % 8;
            end
            n_checks++;
            if (pos < 0 || segdisp_sel_n !== want_sel[pos]) begin
               n_fail++; $display("FAIL scan_walk got sel=%h want %h", segdisp_sel_n, (pos < 0) ? 8'hFE : want_sel[pos]);
               pos = 0;
            end
            prev = segdisp_sel_n;
         end
         digit = pos;
         n_checks++;
         if (segdisp_data !== ((digit < 4) ? 8'hB0 : 8'hC0)) begin
            n_fail++; $display("FAIL scan_digit%0d got %h want %h", digit, segdisp_data, (digit < 4) ? 8'hB0 : 8'hC0);
         end
         @(posedge clk); #1;
      end
      psram_const = 1'b0;
   endtask

   task automatic uart_send(input logic [7:0] b);
      @(negedge clk); com_RxD = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         com_RxD = b[i];
         repeat (BAUD) @(negedge clk);
      end
      com_RxD = 1'b1;
   endtask

   task automatic test_uart();
      logic [7:0] echo;
      int         guard;
      apply_reset(1'b0, 1'b0);
      uart_send(8'hA5);
`ifdef SYSTEM_UART_EN
      guard = 0;
      do begin @(posedge clk); #1; guard++; end while (com_TxD && guard < 100);
      repeat (BAUD / 2) @(posedge clk); #1;
      n_checks++;
      if (com_TxD !== 1'b0) begin
         n_fail++; $display("FAIL uart_tx_start got %b want 0 (waited %0d)", com_TxD, guard);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (BAUD) @(posedge clk); #1;
         echo[i] = com_TxD;
      end
      repeat (BAUD) @(posedge clk); #1;
      n_checks++;
      if (com_TxD !== 1'b1) begin
         n_fail++; $display("FAIL uart_tx_stop got %b want 1", com_TxD);
      end
      n_checks++;
      if (echo !== 8'hA5) begin
         n_fail++; $display("FAIL uart_echo got %h want A5", echo);
      end
      n_checks++;
      if (dut.rx_byte !== 8'hA5) begin
         n_fail++; $display("FAIL uart_rx_byte got %h want A5", dut.rx_byte);
      end
`else
      guard = 0;
      for (int c = 0; c < 20 * BAUD; c++) begin
         @(posedge clk); #1;
         if (com_TxD !== 1'b1) guard++;
      end
      n_checks++;
      if (guard != 0) begin
         n_fail++; $display("FAIL uart_off_txd got %0d low cycles want 0", guard);
      end
      n_checks++;
      if (dut.rx_byte !== 8'd0) begin
         n_fail++; $display("FAIL uart_off_rx_byte got %h want 00", dut.rx_byte);
      end
`endif
   endtask

   // Reset asserted in the middle of the second PSRAM read
   task automatic test_reset_mid_read();
      int guard;
      psram_const = 1'b0;
      apply_reset(1'b1, 1'b1);
      guard = 0;
      while (psram_addr !== 23'h400001 && guard < 60) begin @(posedge clk); #1; guard++; end
      while (psram_ce && guard < 120) begin @(posedge clk); #1; guard++; end
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (psram_ce !== 1'b0 || psram_addr !== 23'h400001) begin
         n_fail++; $display("FAIL midread_setup got ce=%b pc=%h want 0/400001", psram_ce, psram_addr);
      end
      boot_addr_sel = 1'b0;
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if (psram_ce !== 1'b1 || psram_oe !== 1'b1) begin
         n_fail++; $display("FAIL midread_ce_oe got %b%b want 11", psram_ce, psram_oe);
      end
      n_checks++;
      if (psram_addr !== 23'h0 || led_out !== 16'h0) begin
         n_fail++; $display("FAIL midread_pc got pc=%h instr=%h want 0/0", psram_addr, led_out);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; rst_counter = 1'b0; rom_selector = 1'b0; boot_addr_sel = 1'b0;
      disp_sel = 3'd0; com_RxD = 1'b1; psram_const = 1'b0;
      test_reset();
      test_clocks_rom();
      test_psram();
      test_counter();
      test_scan();
      test_uart();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
